// File: rtl/descriptor_select_mp.sv
// descriptor_select_mp: N-source descriptor arbiter (fixed / round-robin)
// into one registered valid/ready output stage with a delivered counter.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   iv_tsntag/pkt_type/bufid  per-source fields, port k at [k*W +: W]
//   iv_descriptor_wr      per-source request, held until acked
//   ov_descriptor_ack     one-cycle ack to the granted source
//   i_rr_mode             1 = round-robin, 0 = fixed (port 0 highest)
//   ov_tsntag/pkt_type/descriptor/src_port, o_descriptor_wr  output stage
//   i_descriptor_ready    downstream ready
//   ov_desc_cnt           wrapping count of descriptors delivered
module descriptor_select_mp #(
  parameter int NUM_PORTS = 4,
  parameter int TAG_W     = 48,
  parameter int TYPE_W    = 3,
  parameter int BUFID_W   = 9,
  parameter int CNT_W     = 32,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_PORTS*TAG_W-1:0]   iv_tsntag,
  input  logic [NUM_PORTS*TYPE_W-1:0]  iv_pkt_type,
  input  logic [NUM_PORTS*BUFID_W-1:0] iv_bufid,
  input  logic [NUM_PORTS-1:0]        iv_descriptor_wr,
  output logic [NUM_PORTS-1:0]        ov_descriptor_ack,
  input  logic                        i_rr_mode,
  output logic [TAG_W-1:0]            ov_tsntag,
  output logic [TYPE_W-1:0]           ov_pkt_type,
  output logic [BUFID_W-1:0]          ov_descriptor,
  output logic [PW-1:0]               ov_src_port,
  output logic                        o_descriptor_wr,
  input  logic                        i_descriptor_ready,
  output logic [CNT_W-1:0]            ov_desc_cnt
);

  logic [NUM_PORTS-1:0] eligible;
  logic                 can_load;
  logic                 xfer;
  logic                 any_req;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        fp_win;
  logic [PW-1:0]        rr_win;
  logic                 rr_hit;
  logic [PW-1:0]        win;
  int                   idx;

  // The port acked this cycle may still show wr from a registered
  // source; masking it prevents capturing the same descriptor twice.
  assign eligible = iv_descriptor_wr & ~ov_descriptor_ack;
  assign any_req  = |eligible;
  assign xfer     = o_descriptor_wr & i_descriptor_ready;
  assign can_load = ~o_descriptor_wr | i_descriptor_ready;

  always_comb begin
    fp_win = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (eligible[i]) fp_win = PW'(i);
    end
  end

  // Search ptr+1, ptr+2, ... wrapping; first hit wins.
  always_comb begin
    rr_win = '0;
    rr_hit = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (!rr_hit && eligible[idx]) begin
        rr_win = PW'(idx);
        rr_hit = 1'b1;
      end
    end
  end

  assign win = i_rr_mode ? rr_win : fp_win;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_descriptor_wr   <= 1'b0;
      ov_tsntag         <= '0;
      ov_pkt_type       <= '0;
      ov_descriptor     <= '0;
      ov_src_port       <= '0;
      ov_descriptor_ack <= '0;
      ov_desc_cnt       <= '0;
      ptr               <= PW'(NUM_PORTS - 1);
    end else begin
      ov_descriptor_ack <= '0;
      if (xfer) ov_desc_cnt <= ov_desc_cnt + CNT_W'(1);
      if (can_load) begin
        o_descriptor_wr <= any_req;
        if (any_req) begin
          ov_tsntag <= iv_tsntag[int'(win)*TAG_W +: TAG_W];
          ov_pkt_type <=
            iv_pkt_type[int'(win)*TYPE_W +: TYPE_W];
          ov_descriptor <=
            iv_bufid[int'(win)*BUFID_W +: BUFID_W];
          ov_src_port       <= win;
          ov_descriptor_ack <= NUM_PORTS'(1) << win;
          ptr               <= win;
        end
      end
    end
  end

endmodule

// File: tb/tb_descriptor_select_mp.sv
// tb_descriptor_select_mp: directed bench for descriptor_select_mp.
// Inputs driven and outputs checked on the falling clock edge.
module tb_descriptor_select_mp;

  logic clk;
  logic rst;
  logic [3:0][47:0] tag;
  logic [3:0][2:0]  ptype;
  logic [3:0][8:0]  bufid;
  logic [3:0]       wr;
  logic [3:0]       ack;
  logic             rr;
  logic [47:0]      o_tag;
  logic [2:0]       o_type;
  logic [8:0]       o_desc;
  logic [1:0]       o_src;
  logic             o_wr;
  logic             ready;
  logic [31:0]      cnt;

  logic             w_rst;
  logic [1:0]       w_wr;
  logic [1:0]       w_ack;
  logic [47:0]      w_tag;
  logic [2:0]       w_type;
  logic [8:0]       w_desc;
  logic [0:0]       w_src;
  logic             w_owr;
  logic [2:0]       w_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int e;

  descriptor_select_mp dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .iv_tsntag          (tag),
    .iv_pkt_type        (ptype),
    .iv_bufid           (bufid),
    .iv_descriptor_wr   (wr),
    .ov_descriptor_ack  (ack),
    .i_rr_mode          (rr),
    .ov_tsntag          (o_tag),
    .ov_pkt_type        (o_type),
    .ov_descriptor      (o_desc),
    .ov_src_port        (o_src),
    .o_descriptor_wr    (o_wr),
    .i_descriptor_ready (ready),
    .ov_desc_cnt        (cnt)
  );

  descriptor_select_mp #(
    .NUM_PORTS(2), .CNT_W(3)
  ) u_wrap (
    .i_clk              (clk),
    .i_rst              (w_rst),
    .iv_tsntag          ({48'h2, 48'h1}),
    .iv_pkt_type        ({3'd2, 3'd1}),
    .iv_bufid           ({9'h2, 9'h1}),
    .iv_descriptor_wr   (w_wr),
    .ov_descriptor_ack  (w_ack),
    .i_rr_mode          (1'b0),
    .ov_tsntag          (w_tag),
    .ov_pkt_type        (w_type),
    .ov_descriptor      (w_desc),
    .ov_src_port        (w_src),
    .o_descriptor_wr    (w_owr),
    .i_descriptor_ready (1'b1),
    .ov_desc_cnt        (w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string tag_s,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag_s, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_port(
    input int k,
    input logic [8:0] b,
    input logic [2:0] t,
    input logic [47:0] g
  );
    bufid[k] = b;
    ptype[k] = t;
    tag[k]   = g;
  endtask

  initial begin
    rst = 1'b1; wr = '0; ready = 1'b1; rr = 1'b0;
    tag = '0; ptype = '0; bufid = '0;
    w_rst = 1'b1; w_wr = '0;
    @(negedge clk);
    cyc();
    check("rst_wr", o_wr, 0);
    check("rst_ack", ack, 0);
    check("rst_cnt", cnt, 0);
    check("rst_desc", o_desc, 0);
    check("rst_src", o_src, 0);

    // single request, latency 1
    rst = 1'b0;
    set_port(2, 9'h05, 3'd3, 48'hA5);
    wr = 4'b0100;
    cyc();
    check("t1_wr", o_wr, 1);
    check("t1_desc", o_desc, 9'h05);
    check("t1_type", o_type, 3);
    check("t1_tag", o_tag, 48'hA5);
    check("t1_src", o_src, 2);
    check("t1_ack", ack, 4'b0100);
    wr = '0;
    cyc();
    check("t1_cnt", cnt, 1);
    check("t1_idle", o_wr, 0);
    check("t1_ack0", ack, 0);

    // fixed priority, all ports requesting
    for (int k = 0; k < 4; k++)
      set_port(k, 9'h10 + 9'(k), 3'(k), 48'h1000 + 48'(k));
    wr = 4'hF;
    for (int i = 0; i < 6; i++) begin
      cyc();
      e = i % 2;
      check("fp_src", o_src, 64'(e));
      check("fp_ack", ack, 64'(1) << e);
      check("fp_desc", o_desc, 64'(9'h10 + 9'(e)));
      check("fp_wr", o_wr, 1);
    end
    wr = '0;
    cyc();
    check("fp_cnt", cnt, 7);
    check("fp_idle", o_wr, 0);

    // round-robin from reset pointer
    rst = 1'b1;
    cyc();
    rst = 1'b0; rr = 1'b1; wr = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cyc();
      e = i % 4;
      check("rr_src", o_src, 64'(e));
      check("rr_ack", ack, 64'(1) << e);
      check("rr_tag", o_tag, 64'(48'h1000 + 48'(e)));
      check("rr_wr", o_wr, 1);
    end
    wr = '0;
    cyc();
    check("rr_cnt", cnt, 8);
    check("rr_idle", o_wr, 0);

    // backpressure, then back-to-back reload
    ready = 1'b0;
    set_port(1, 9'h21, 3'd1, 48'h21);
    wr = 4'b0010;
    cyc();
    check("bp_wr", o_wr, 1);
    check("bp_desc", o_desc, 9'h21);
    check("bp_src", o_src, 1);
    check("bp_ack", ack, 4'b0010);
    set_port(3, 9'h33, 3'd7, 48'h33);
    wr = 4'b1000;
    for (int i = 0; i < 9; i++) begin
      cyc();
      check("bp_hold_wr", o_wr, 1);
      check("bp_hold_desc", o_desc, 9'h21);
      check("bp_hold_ack", ack, 0);
    end
    check("bp_cnt0", cnt, 8);
    ready = 1'b1;
    cyc();
    check("bb_cnt", cnt, 9);
    check("bb_wr", o_wr, 1);
    check("bb_desc", o_desc, 9'h33);
    check("bb_src", o_src, 3);
    check("bb_ack", ack, 4'b1000);
    wr = '0; ready = 1'b0;
    cyc();
    check("bb_hold", o_desc, 9'h33);
    check("bb_ack0", ack, 0);
    check("bb_cnt1", cnt, 9);

    // reset while output held
    rst = 1'b1;
    cyc();
    check("mr_wr", o_wr, 0);
    check("mr_cnt", cnt, 0);
    check("mr_desc", o_desc, 0);
    check("mr_tag", o_tag, 0);
    check("mr_src", o_src, 0);
    check("mr_ack", ack, 0);
    rst = 1'b0; ready = 1'b1;
    cyc();
    cyc();
    check("mr_idle", o_wr, 0);
    check("mr_cnt0", cnt, 0);
    wr = 4'b1000;
    cyc();
    check("mr_p3_src", o_src, 3);
    check("mr_p3_ack", ack, 4'b1000);
    wr = '0;
    cyc();
    check("mr_p3_cnt", cnt, 1);
    wr = 4'b1001;
    cyc();
    check("rr_wrap_src", o_src, 0);
    cyc();
    check("rr_next_src", o_src, 3);
    wr = '0;
    cyc();

    // counter wrap on a 3-bit instance
    w_rst = 1'b0;
    w_wr = 2'b01;
    for (int i = 0; i < 14; i++) cyc();
    check("wrap_cnt7", w_cnt, 7);
    cyc();
    cyc();
    check("wrap_cnt0", w_cnt, 0);
    w_wr = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/descriptor_select_mp.md
Name: descriptor_select_mp

Overview:
Parametrised N-input successor to the two-input host/network descriptor selector in the network output path. It arbitrates descriptors (tsntag, pkt_type, bufid) from NUM_PORTS sources into one registered output stage using valid/ready. The output stage feeds network_input_queue. Arbitration is run-time selectable between fixed priority and round-robin, and a wrapping count of delivered descriptors is kept.

Parameters:
NUM_PORTS, 4, number of descriptor sources (2..16)
TAG_W, 48, tsntag width
TYPE_W, 3, pkt_type width
BUFID_W, 9, bufid width
CNT_W, 32, delivered-descriptor counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
iv_tsntag  in  NUM_PORTS*TAG_W  per-port tsntag; port k at [k*TAG_W +: TAG_W]
iv_pkt_type  in  NUM_PORTS*TYPE_W  per-port pkt_type, same packing
iv_bufid  in  NUM_PORTS*BUFID_W  per-port bufid, same packing
iv_descriptor_wr  in  NUM_PORTS  per-port request, held with stable data until acked
ov_descriptor_ack  out  NUM_PORTS  one-cycle ack pulse to the granted port
i_rr_mode  in  1  1 = round-robin, 0 = fixed priority (port 0 highest)
ov_tsntag  out  TAG_W  output tsntag
ov_pkt_type  out  TYPE_W  output pkt_type
ov_descriptor  out  BUFID_W  output bufid
ov_src_port  out  max(1,$clog2(NUM_PORTS))  index of the granting port
o_descriptor_wr  out  1  output valid
i_descriptor_ready  in  1  downstream ready
ov_desc_cnt  out  CNT_W  descriptors delivered downstream

Behaviour:
- Reset (i_clk edge with i_rst=1): all outputs 0, output stage empty, rr pointer = NUM_PORTS-1 (port 0 wins first round-robin grant). Reset mid-transfer drops the held descriptor with no ack and no count.
- Transfer: o_descriptor_wr && i_descriptor_ready in the same cycle. o_descriptor_wr stays high and payload stays stable until transfer. Payload is don't-care while o_descriptor_wr=0.
- can_load = !o_descriptor_wr || i_descriptor_ready.
- eligible[k] = iv_descriptor_wr[k] && !ov_descriptor_ack[k]. Masking the acked port for its ack cycle stops double-capture while a registered source drops wr.
- Arbitration cycle: can_load and any eligible. On the next edge: load the winner's fields into the output stage, set o_descriptor_wr=1, ov_src_port=winner, and pulse ov_descriptor_ack[winner]=1 for exactly one cycle. All other ack bits are 0.
- can_load with no eligible request: o_descriptor_wr goes 0 if a transfer occurred, otherwise it stays 0.
- Fixed priority: lowest eligible index wins.
- Round-robin: first eligible index searching ptr+1, ptr+2, … modulo NUM_PORTS. ptr updates to the winner on every grant in either mode, so a switch to RR resumes after the last grant. i_rr_mode is sampled in the arbitration cycle only.
- Latency: a request in cycle t with the stage empty gives o_descriptor_wr and ack in cycle t+1.
- Throughput: one descriptor per cycle while i_descriptor_ready=1 and distinct ports request. A single port alone is served at most every 2 cycles.
- Backpressure: while i_descriptor_ready=0 and the stage is full, no grants and no acks occur, and requests wait indefinitely.
- Transfer and new load in the same cycle: both happen. The output reloads with no bubble.
- Counter: ov_desc_cnt increments by 1 per transfer and wraps from 2^CNT_W-1 to 0.
- Request dropped before ack (protocol violation): that port is simply not eligible. No error is flagged.

Test Plan:
- Reset, then port 2 requests bufid 9'h05, pkt_type 3, tsntag 48'hA5 with ready=1 -> cycle t+1: o_descriptor_wr=1, ov_descriptor=5, ov_src_port=2, ack=4'b0100 for 1 cycle; ov_desc_cnt=1 after transfer.
- Fixed mode, ports 0–3 hold requests continuously (re-request after each ack), ready=1 -> grant order 0,1,0,1,…; ports 2 and 3 starve.
- RR mode, same stimulus -> grants 0,1,2,3,0,… with one descriptor per cycle and no bubbles; each ack is exactly 1 cycle.
- Port 1 requests, ready=0 for 10 cycles -> o_descriptor_wr held with stable payload and a single ack; ready=1 -> one transfer and cnt increments once; port 3 requesting meanwhile is granted in the transfer cycle, reloaded back-to-back.
- Preload ov_desc_cnt to 32'hFFFF_FFFF (force), one transfer -> 0.
- Assert i_rst while output is valid with ready=0 -> next cycle all outputs 0; after release with no requests, o_descriptor_wr stays 0 and a new port 3 request is granted before port 0 in RR only if port 0 is not requesting.
